// File: rtl/batalha_pkg.sv
// -----------------------------------------------------------------------------
// batalha_pkg
//  Constants shared by the ship-position store and its clients:
//   - NUM_EMB / WORD_W / NUM_WORDS geometry of the ship-mask store
//   - ship index constants (row of the store inside one player's bank)
//   - FSM state encoding of the store (LIMPANDO, OCIOSO)
//   - indice(): flat word index = jogador*NUM_EMB + addr
// -----------------------------------------------------------------------------
package batalha_pkg;

  localparam int NUM_EMB   = 11;
  localparam int WORD_W    = 64;
  localparam int NUM_WORDS = 2 * NUM_EMB;
  localparam int IDX_W     = 5;

  // Ship index constants
  localparam logic [IDX_W-1:0] SUBMARINO_UM    = 5'd0;
  localparam logic [IDX_W-1:0] SUBMARINO_DOIS  = 5'd1;
  localparam logic [IDX_W-1:0] SUBMARINO_TRES  = 5'd2;
  localparam logic [IDX_W-1:0] SUBMARINO_QUATRO = 5'd3;
  localparam logic [IDX_W-1:0] SUBMARINO_CINCO = 5'd4;
  localparam logic [IDX_W-1:0] CRUZADOR_UM     = 5'd5;
  localparam logic [IDX_W-1:0] CRUZADOR_DOIS   = 5'd6;
  localparam logic [IDX_W-1:0] HIDROAVIAO_UM   = 5'd7;
  localparam logic [IDX_W-1:0] HIDROAVIAO_DOIS = 5'd8;
  localparam logic [IDX_W-1:0] ENCOURACADO     = 5'd9;
  localparam logic [IDX_W-1:0] PORTA_AVIOES    = 5'd10;

  // FSM state encoding
  localparam logic [0:0] LIMPANDO = 1'b0;
  localparam logic [0:0] OCIOSO   = 1'b1;

  // Flat word index; only meaningful when a < NUM_EMB.
  function automatic logic [IDX_W-1:0] indice(input logic jog, input logic [IDX_W-1:0] a);
    return jog ? (a + IDX_W'(NUM_EMB)) : a;
  endfunction

endpackage

// File: rtl/mapa_embarcacoes_banco.sv
// -----------------------------------------------------------------------------
// mapa_embarcacoes_banco
//  Flop array of NUM_WORDS x WORD_W with one write port and one registered
//  read port. Read-first: a read and write to the same word on the same edge
//  returns the old contents. No reset on the array; the owner clears it with
//  a sweep and masks reads until the sweep is done.
// Ports
//  clk    in   1       clock
//  we     in   1       write enable
//  waddr  in   IDX_W   write word index (< NUM_WORDS)
//  wdata  in   WORD_W  write data
//  raddr  in   IDX_W   read word index (< NUM_WORDS)
//  rdata  out  WORD_W  registered read data
// -----------------------------------------------------------------------------
module mapa_embarcacoes_banco
  import batalha_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [NUM_WORDS];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mapa_embarcacoes_mem.sv
// -----------------------------------------------------------------------------
// mapa_embarcacoes_mem
//  Ship-position store for the VGA compositor: one WORD_W board mask per ship
//  (NUM_EMB ships) for each of 2 players. Registered read port for the VGA
//  sweep, valid/ready write port for the piece-positioning logic, and a
//  self-clearing sweep after reset or on a limpar request.
//  Build option: VGA_MEM_BYPASS_EN -> same-index same-cycle read returns the
//  data being written (write-first); otherwise read-first.
// Ports
//  clk           in   1        system clock
//  resetGeral    in   1        asynchronous active-high reset
//  jogadorVGA    in   1        read player select
//  addr          in   5        read ship index
//  data_memoria  out  WORD_W   registered read data
//  wr_valid      in   1        write request
//  wr_ready      out  1        write accept (combinational)
//  wr_jogador    in   1        write player select
//  wr_addr       in   5        write ship index
//  wr_data       in   WORD_W   ship mask to store
//  wr_erro       out  1        1-cycle pulse: accepted write with wr_addr >= NUM_EMB
//  limpar        in   1        clear request (level)
//  limpando      out  1        clear sweep in progress
//  ocupacao_j0   out  NUM_EMB  bit i set iff player-0 word i is nonzero
//  ocupacao_j1   out  NUM_EMB  bit i set iff player-1 word i is nonzero
// -----------------------------------------------------------------------------
module mapa_embarcacoes_mem
  import batalha_pkg::*;
(
  input  logic               clk,
  input  logic               resetGeral,
  input  logic               jogadorVGA,
  input  logic [4:0]         addr,
  output logic [WORD_W-1:0]  data_memoria,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic               wr_jogador,
  input  logic [4:0]         wr_addr,
  input  logic [WORD_W-1:0]  wr_data,
  output logic               wr_erro,
  input  logic               limpar,
  output logic               limpando,
  output logic [NUM_EMB-1:0] ocupacao_j0,
  output logic [NUM_EMB-1:0] ocupacao_j1
);

  logic [0:0]           state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic                 wr_erro_q, wr_erro_d;
  logic [NUM_WORDS-1:0] ocup_q, ocup_d;
  logic                 zero_q, zero_d;   // force read data to 0 this cycle

  logic                 wr_acc, wr_addr_ok, rd_ok;
  logic [IDX_W-1:0]     wr_idx, rd_idx;
  logic                 bank_we;
  logic [IDX_W-1:0]     bank_waddr;
  logic [WORD_W-1:0]    bank_wdata, bank_rdata;

  assign wr_ready   = (state_q == OCIOSO) && !limpar;
  assign wr_acc     = wr_valid && wr_ready;
  assign wr_addr_ok = wr_addr < IDX_W'(NUM_EMB);
  assign wr_idx     = indice(wr_jogador, wr_addr);
  assign rd_ok      = addr < IDX_W'(NUM_EMB);
  // Out-of-range read addresses are parked on word 0 and masked to zero.
  assign rd_idx     = rd_ok ? indice(jogadorVGA, addr) : '0;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    ocup_d     = ocup_q;
    wr_erro_d  = 1'b0;
    bank_we    = 1'b0;
    bank_waddr = wr_idx;
    bank_wdata = wr_data;
    case (state_q)
      LIMPANDO: begin
        // One word zeroed per cycle; limpar has no effect until the sweep ends.
        bank_we    = 1'b1;
        bank_waddr = ptr_q;
        bank_wdata = '0;
        ocup_d     = '0;
        if (ptr_q == IDX_W'(NUM_WORDS - 1)) begin
          state_d = OCIOSO;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      OCIOSO: begin
        if (limpar) begin
          state_d = LIMPANDO;
          ptr_d   = '0;
          ocup_d  = '0;
        end else if (wr_acc) begin
          if (wr_addr_ok) begin
            bank_we        = 1'b1;
            ocup_d[wr_idx] = |wr_data;
          end else begin
            wr_erro_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = LIMPANDO;
        ptr_d   = '0;
      end
    endcase
  end

  assign zero_d = (state_q == LIMPANDO) || !rd_ok;

  always_ff @(posedge clk or posedge resetGeral) begin
    if (resetGeral) begin
      state_q   <= LIMPANDO;
      ptr_q     <= '0;
      wr_erro_q <= 1'b0;
      ocup_q    <= '0;
      zero_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wr_erro_q <= wr_erro_d;
      ocup_q    <= ocup_d;
      zero_q    <= zero_d;
    end
  end

  mapa_embarcacoes_banco u_banco (
    .clk   (clk),
    .we    (bank_we),
    .waddr (bank_waddr),
    .wdata (bank_wdata),
    .raddr (rd_idx),
    .rdata (bank_rdata)
  );

`ifdef VGA_MEM_BYPASS_EN
  // Write-first: remember that this cycle's read hit the word being written.
  logic              byp_q;
  logic [WORD_W-1:0] byp_data_q;

  always_ff @(posedge clk or posedge resetGeral) begin
    if (resetGeral) begin
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      byp_q      <= wr_acc && wr_addr_ok && rd_ok && (wr_idx == rd_idx);
      byp_data_q <= wr_data;
    end
  end

  assign data_memoria = zero_q ? '0 : (byp_q ? byp_data_q : bank_rdata);
`else
  assign data_memoria = zero_q ? '0 : bank_rdata;
`endif

  assign wr_erro     = wr_erro_q;
  assign limpando    = (state_q == LIMPANDO);
  assign ocupacao_j0 = ocup_q[NUM_EMB-1:0];
  assign ocupacao_j1 = ocup_q[NUM_WORDS-1:NUM_EMB];

endmodule

// File: tb/tb_mapa_embarcacoes_mem.sv
// -----------------------------------------------------------------------------
// tb_mapa_embarcacoes_mem
//  Directed bench for mapa_embarcacoes_mem with a per-player/per-ship array
//  model and a per-cycle compare process, plus literal expectations.
// -----------------------------------------------------------------------------
module tb_mapa_embarcacoes_mem;
  import batalha_pkg::*;

`ifdef VGA_MEM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetGeral, jogadorVGA, wr_valid, wr_jogador, limpar;
  logic [4:0] addr, wr_addr;
  logic [WORD_W-1:0] wr_data, data_memoria;
  logic wr_ready, wr_erro, limpando;
  logic [NUM_EMB-1:0] ocupacao_j0, ocupacao_j1;

  always #5 clk = ~clk;

  mapa_embarcacoes_mem dut (
    .clk(clk), .resetGeral(resetGeral), .jogadorVGA(jogadorVGA), .addr(addr),
    .data_memoria(data_memoria), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_jogador(wr_jogador), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_erro(wr_erro), .limpar(limpar), .limpando(limpando),
    .ocupacao_j0(ocupacao_j0), .ocupacao_j1(ocupacao_j1)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [WORD_W-1:0] m_mem [2][NUM_EMB];
  int                m_clear = 0;   // sweep cycles remaining
  logic [WORD_W-1:0] m_data = '0;
  logic              m_erro = 1'b0;
  logic              m_acc;

  task automatic m_zero_all();
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < NUM_EMB; i++) m_mem[j][i] = '0;
  endtask

  function automatic logic [NUM_EMB-1:0] m_occ(input int j);
    logic [NUM_EMB-1:0] r;
    for (int i = 0; i < NUM_EMB; i++) r[i] = (m_mem[j][i] != '0);
    return r;
  endfunction

  always @(posedge clk or posedge resetGeral) begin
    if (resetGeral) begin
      m_clear = 2 * NUM_EMB;
      m_data  = '0;
      m_erro  = 1'b0;
      m_zero_all();
    end else begin
      m_acc = wr_valid && (m_clear == 0) && !limpar;
      if (m_clear > 0 || addr >= NUM_EMB) m_data = '0;
      else if (BYP && m_acc && wr_addr < NUM_EMB && wr_jogador == jogadorVGA && wr_addr == addr)
        m_data = wr_data;
      else m_data = m_mem[jogadorVGA][addr];
      m_erro = m_acc && (wr_addr >= NUM_EMB);
      if (m_clear > 0) m_clear--;
      else if (limpar) begin
        m_clear = 2 * NUM_EMB;
        m_zero_all();
      end else if (m_acc && wr_addr < NUM_EMB)
        m_mem[wr_jogador][wr_addr] = wr_data;
    end
  end

  // Per-cycle compare, 1 time unit after the active edge.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("cyc_limpando", 64'(limpando), 64'(m_clear > 0));
      check("cyc_wr_ready", 64'(wr_ready), 64'((m_clear == 0) && !limpar));
      check("cyc_data", data_memoria, m_data);
      check("cyc_wr_erro", 64'(wr_erro), 64'(m_erro));
      check("cyc_ocup_j0", 64'(ocupacao_j0), 64'(m_occ(0)));
      check("cyc_ocup_j1", 64'(ocupacao_j1), 64'(m_occ(1)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write(input logic j, input logic [4:0] a, input logic [63:0] d);
    wr_valid = 1'b1; wr_jogador = j; wr_addr = a; wr_data = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic rd(input logic j, input logic [4:0] a);
    jogadorVGA = j; addr = a;
    tick();
  endtask

  // Counts cycles with limpando high, bounded; drops limpar after drop_at samples.
  task automatic count_sweep(output int n, input int drop_at);
    n = 0;
    while (limpando === 1'b1 && n < 100) begin
      check("sweep_ready_low", 64'(wr_ready), 64'd0);
      n++;
      if (n == drop_at) limpar = 1'b0;
      tick();
    end
  endtask

  int n;

  initial begin
    resetGeral = 1'b0; jogadorVGA = 1'b0; addr = '0; wr_valid = 1'b0;
    wr_jogador = 1'b0; wr_addr = '0; wr_data = '0; limpar = 1'b0;
    #1 resetGeral = 1'b1;
    chk_en = 1'b1;
    tick(); tick();
    // 1. reset state and sweep length
    check("rst_limpando", 64'(limpando), 64'd1);
    check("rst_wr_ready", 64'(wr_ready), 64'd0);
    check("rst_data", data_memoria, 64'd0);
    check("rst_ocup", 64'({ocupacao_j1, ocupacao_j0}), 64'd0);
    resetGeral = 1'b0;
    count_sweep(n, 0);
    check("sweep_len_reset", 64'(n), 64'd22);
    check("ready_after_sweep", 64'(wr_ready), 64'd1);

    // 2. write/read
    write(1'b1, ENCOURACADO, 64'hF0);
    rd(1'b1, 5'd9);
    check("read_j1_a9", data_memoria, 64'hF0);
    rd(1'b0, 5'd9);
    check("read_j0_a9", data_memoria, 64'h0);
    check("ocup_j1_200", 64'(ocupacao_j1), 64'h200);
    check("ocup_j0_0", 64'(ocupacao_j0), 64'h0);

    // 3. out-of-range write
    write(1'b0, 5'd11, 64'hABCD);
    check("erro_pulse", 64'(wr_erro), 64'd1);
    tick();
    check("erro_drop", 64'(wr_erro), 64'd0);
    check("erro_ocup", 64'({ocupacao_j1, ocupacao_j0}), 64'({11'h200, 11'h000}));
    rd(1'b1, 5'd9);
    check("erro_keep_word", data_memoria, 64'hF0);

    // more patterns: other ships, clearing bit with zero data, out-of-range read
    write(1'b0, PORTA_AVIOES, 64'h5);
    write(1'b1, SUBMARINO_UM, 64'hFFFF_0000_0000_0001);
    check("ocup_mix_j0", 64'(ocupacao_j0), 64'h400);
    check("ocup_mix_j1", 64'(ocupacao_j1), 64'h201);
    write(1'b1, ENCOURACADO, 64'h0);
    check("ocup_clear_bit", 64'(ocupacao_j1), 64'h001);
    rd(1'b1, 5'd15);
    check("read_oob", data_memoria, 64'h0);
    rd(1'b1, 5'd0);
    check("read_j1_a0", data_memoria, 64'hFFFF_0000_0000_0001);
    write(1'b1, 5'd31, 64'h1);
    check("erro_pulse_31", 64'(wr_erro), 64'd1);

    // 5. same-index read/write
    write(1'b0, SUBMARINO_QUATRO, 64'h1);
    jogadorVGA = 1'b0; addr = 5'd3;
    wr_valid = 1'b1; wr_jogador = 1'b0; wr_addr = 5'd3; wr_data = 64'h8;
    tick();
    wr_valid = 1'b0;
    check("collision_read", data_memoria, BYP ? 64'h8 : 64'h1);
    tick();
    check("after_collision", data_memoria, 64'h8);

    // 4. limpar with a pending write
    limpar = 1'b1; wr_valid = 1'b1; wr_jogador = 1'b0; wr_addr = 5'd2; wr_data = 64'h77;
    #1;
    check("limpar_ready_low", 64'(wr_ready), 64'd0);
    tick();
    wr_valid = 1'b0;
    check("limpar_ocup_cleared", 64'({ocupacao_j1, ocupacao_j0}), 64'd0);
    count_sweep(n, 5);
    check("sweep_len_limpar", 64'(n), 64'd22);
    for (int j = 0; j < 2; j++)
      for (int a = 0; a < NUM_EMB; a++) begin
        rd(j[0], 5'(a));
        check("post_clear_read", data_memoria, 64'h0);
      end
    check("post_clear_ocup", 64'({ocupacao_j1, ocupacao_j0}), 64'd0);

    // 6. reset mid-sweep
    resetGeral = 1'b1;
    tick();
    resetGeral = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_sweep_busy", 64'(limpando), 64'd1);
    resetGeral = 1'b1;
    tick();
    resetGeral = 1'b0;
    count_sweep(n, 0);
    check("sweep_len_restart", 64'(n), 64'd22);

    write(1'b0, CRUZADOR_DOIS, 64'h3C);
    rd(1'b0, 5'd6);
    check("final_read", data_memoria, 64'h3C);
    check("final_ocup_j0", 64'(ocupacao_j0), 64'h040);
    tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
